// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register-file write-back arbiter.
//   NREQ/XLEN/AW/CNT_W : default arbiter geometry
//   REG_ZERO           : hard-wired zero register index (writes are discarded)
//   REQ_ALU/LSU/MDU    : requester slot assignment on the arbiter inputs
package regfile_pkg;

    localparam int NREQ     = 3;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int CNT_W    = 16;
    localparam int REG_ZERO = 0;

    typedef enum int {
        REQ_ALU = 0,
        REQ_LSU = 1,
        REQ_MDU = 2
    } req_id_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req  in  N   request vector
//   last in  LW  index granted most recently; search starts just after it
//   en   in  1   grant enable; gnt is zero when low
//   gnt  out N   one-hot grant to the first requester after last (wrapping)
module rr_arbiter #(
    parameter int N  = 3,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  gnt
);

    logic [LW-1:0] w_idx;

    always_comb begin
        gnt   = '0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = LW'((int'(last) + k) % N);
            if (en && gnt == '0 && req[w_idx]) gnt[w_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between NREQ write-back sources.
//   clk, rst (sync, active-high)     clock / reset
//   hold                             stall, suppresses all grants
//   req_valid/req_rd/req_data        requester i in slices [i], [i*AW +: AW], [i*XLEN +: XLEN]
//   req_ready                        one-hot grant, transfer on valid&ready
//   rf_we/rf_waddr/rf_wdata          registered write port to the register file
//   wb_busy                          a valid requester went ungranted this cycle
//   conflict_cnt                     saturating count of cycles with >=2 valid requests
//   rs1/rs2 addr, rf_data -> data    read-port pass-through, with forwarding of the
//                                    in-flight write when WB_BYPASS_EN is defined
module regfile_wb_arbiter #(
    parameter int NREQ  = regfile_pkg::NREQ,
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int AW    = regfile_pkg::AW,
    parameter int CNT_W = regfile_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 wb_busy,
    output logic [CNT_W-1:0]     conflict_cnt,
    input  logic [AW-1:0]        rs1_addr,
    input  logic [AW-1:0]        rs2_addr,
    input  logic [XLEN-1:0]      rs1_rf_data,
    input  logic [XLEN-1:0]      rs2_rf_data,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data
);

    import regfile_pkg::*;

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0]    r_last;
    logic             r_we;
    logic [AW-1:0]    r_waddr;
    logic [XLEN-1:0]  r_wdata;
    logic [CNT_W-1:0] r_cnt;

    logic [NREQ-1:0]  w_gnt;
    logic             w_xfer;
    logic             w_multi;
    logic [LW-1:0]    w_idx;
    logic [AW-1:0]    w_rd;
    logic [XLEN-1:0]  w_data;

    rr_arbiter #(.N(NREQ), .LW(LW)) u_rr (
        .req  (req_valid),
        .last (r_last),
        .en   (~hold),
        .gnt  (w_gnt)
    );

    // The grant is one-hot, so OR-ing the selected slices is a plain mux.
    always_comb begin
        w_idx  = '0;
        w_rd   = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_idx  = LW'(i);
                w_rd   = w_rd | req_rd[i*AW +: AW];
                w_data = w_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_xfer    = |w_gnt;
    // Clearing the lowest set bit leaves something only when two or more are set.
    assign w_multi   = |(req_valid & (req_valid - NREQ'(1)));
    assign req_ready = w_gnt;
    assign wb_busy   = |(req_valid & ~w_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= LW'(NREQ - 1);
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_xfer) begin
            r_last  <= w_idx;
            r_we    <= w_rd != AW'(REG_ZERO);
            r_waddr <= w_rd;
            r_wdata <= w_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (w_multi && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign conflict_cnt = r_cnt;

`ifdef WB_BYPASS_EN
    assign rs1_data = (r_we && r_waddr == rs1_addr && rs1_addr != AW'(REG_ZERO)) ? r_wdata : rs1_rf_data;
    assign rs2_data = (r_we && r_waddr == rs2_addr && rs2_addr != AW'(REG_ZERO)) ? r_wdata : rs2_rf_data;
`else
    logic w_unused;
    assign w_unused = ^{rs1_addr, rs2_addr};
    assign rs1_data = rs1_rf_data;
    assign rs2_data = rs2_rf_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven check of the write-back arbiter with a write-stage scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_busy;
    logic [15:0] conflict_cnt;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rf_data, rs2_rf_data, rs1_data, rs2_data;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .wb_busy      (wb_busy),
        .conflict_cnt (conflict_cnt),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_rf_data  (rs1_rf_data),
        .rs2_rf_data  (rs2_rf_data),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data)
    );

    typedef struct {
        logic        do_rst;
        logic        hold;
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] d;
        logic [2:0]  rdy;
        logic        busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t        tbl[20];
    wr_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        req_rd = '0;
        req_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt = '0;
        sb.delete();
        chk("rst_we", 64'(rf_we), 64'(0));
        chk("rst_waddr", 64'(rf_waddr), 64'(0));
        chk("rst_wdata", 64'(rf_wdata), 64'(0));
        chk("rst_cnt", 64'(conflict_cnt), 64'(0));
    endtask

    task automatic step(input logic h, input logic [2:0] v, input logic [14:0] rd,
                        input logic [95:0] d, input logic [2:0] rdy, input logic busy);
        wr_t e;
        wr_t got;
        hold = h;
        req_valid = v;
        req_rd = rd;
        req_data = d;
        @(negedge clk);
        chk("ready", 64'(req_ready), 64'(rdy));
        chk("busy", 64'(wb_busy), 64'(busy));
        e.we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rdy[i]) begin
                exp_addr = rd[i*5 +: 5];
                exp_data = d[i*32 +: 32];
                e.we = exp_addr != 5'd0;
            end
        end
        e.addr = exp_addr;
        e.data = exp_data;
        sb.push_back(e);
        if ($countones(v) >= 2) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            got = sb.pop_front();
            chk("rf_we", 64'(rf_we), 64'(got.we));
            chk("rf_waddr", 64'(rf_waddr), 64'(got.addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(got.data));
        end
        chk("cnt", 64'(conflict_cnt), 64'(exp_cnt));
    endtask

    initial begin
        rs1_addr = '0;
        rs2_addr = '0;
        rs1_rf_data = '0;
        rs2_rf_data = '0;
        for (int i = 0; i < 20; i++) tbl[i] = '{1'b0, 1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0};
        tbl[0].do_rst = 1'b1;
        tbl[5]  = '{1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 3'b001, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b001, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b010, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 3'b100, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b001, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b010, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b100, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1, 32'd0}, 3'b010, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 3'b110, {5'd6, 5'd4, 5'd0}, {32'h66, 32'h44, 32'd0}, 3'b100, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 3'b010, {5'd0, 5'd4, 5'd0}, {32'd0, 32'h44, 32'd0}, 3'b010, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'h88}, 3'b000, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'h88}, 3'b000, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'h88}, 3'b000, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 3'b001, {5'd0, 5'd0, 5'd8}, {32'd0, 32'd0, 32'h88}, 3'b001, 1'b0};

        for (int i = 0; i < 20; i++) begin
            if (tbl[i].do_rst) do_reset();
            step(tbl[i].hold, tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].rdy, tbl[i].busy);
            if (i == 11) chk("cnt_after_6", 64'(conflict_cnt), 64'(6));
        end

        // Forwarding of the in-flight write to the read ports.
        step(1'b0, 3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h55}, 3'b001, 1'b0);
        rs1_addr = 5'd7;
        rs1_rf_data = 32'h0;
        rs2_addr = 5'd3;
        rs2_rf_data = 32'h1234;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_rs1_hit", 64'(rs1_data), 64'h55);
`else
        chk("byp_rs1_hit", 64'(rs1_data), 64'h0);
`endif
        chk("byp_rs2_miss", 64'(rs2_data), 64'h1234);
        rs1_addr = 5'd0;
        rs1_rf_data = 32'hABCD;
        #1;
        chk("byp_rs1_x0", 64'(rs1_data), 64'hABCD);
        rs1_addr = 5'd7;
        rs1_rf_data = 32'h0;
        step(1'b0, 3'b000, 15'd0, 96'd0, 3'b000, 1'b0);
        #1;
        chk("byp_rs1_idle", 64'(rs1_data), 64'h0);

        // Reset on the accepting edge drops the write and reinitialises the pointer.
        hold = 1'b0;
        req_valid = 3'b010;
        req_rd = {5'd0, 5'd9, 5'd0};
        req_data = {32'd0, 32'h99, 32'd0};
        @(negedge clk);
        chk("mid_ready", 64'(req_ready), 64'(3'b010));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_we", 64'(rf_we), 64'(0));
        chk("mid_waddr", 64'(rf_waddr), 64'(0));
        req_valid = 3'b111;
        @(negedge clk);
        chk("mid_ptr", 64'(req_ready), 64'(3'b001));
        req_valid = '0;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
